// File: rtl/hilo_muldiv_unit.sv
// EX-stage multiply/divide engine with the architectural HI/LO pair.
// Pipelined multiply, radix-2 restoring divide, MTHI/MTLO and flush.
module hilo_muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int CMAX = (WIDTH > MUL_STAGES) ? WIDTH : MUL_STAGES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int PW   = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [PW-1:0]    pipe_q [MUL_STAGES];
  logic [PW-1:0]    pipe0_d;

  logic             accept;
  logic             op_valid;
  logic             sgn;
  logic [PW-1:0]    ax, bx, prod;
  logic [WIDTH-1:0] amag, bmag;
  logic [WIDTH:0]   sh, diff;
  logic             ge;
  logic [WIDTH-1:0] rem_n, quo_n;

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

  // Request qualification and operand preconditioning.
  always_comb begin
    op_valid = (op != 3'd0) && (op != 3'd7);
    accept   = start && !busy && !flush && op_valid;
    sgn      = (op == OP_MULT) || (op == OP_DIV);
    ax   = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    bx   = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod = ax * bx;
    amag = (sgn && a[WIDTH-1]) ? -a : a;
    bmag = (sgn && b[WIDTH-1]) ? -b : b;
  end

  // One restoring-division step on the magnitudes.
  always_comb begin
    sh    = {rem_q, quo_q[WIDTH-1]};
    diff  = sh - {1'b0, dvs_q};
    ge    = !diff[WIDTH];
    rem_n = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
    quo_n = {quo_q[WIDTH-2:0], ge};
  end

  // Next-state, counter and HI/LO update logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    pipe0_d = pipe_q[0];
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_d = MUL;
              cnt_d   = CW'(MUL_STAGES);
              pipe0_d = prod;
            end
            OP_DIV, OP_DIVU: begin
              if (b == '0) begin
                done_d = 1'b1;
                dz_d   = 1'b1;
              end else begin
                state_d = DIV;
                cnt_d   = CW'(WIDTH);
                rem_d   = '0;
                quo_d   = amag;
                dvs_d   = bmag;
                qneg_d  = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                rneg_d  = sgn && a[WIDTH-1];
              end
            end
            OP_MTHI: begin
              hi_d   = a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = a;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(1)) begin
          {hi_d, lo_d} = pipe_q[MUL_STAGES-1];
          done_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DIV: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          rem_d = rem_n;
          quo_d = quo_n;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            hi_d    = rneg_q ? -rem_n : rem_n;
            lo_d    = qneg_q ? -quo_n : quo_n;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control, HI/LO and divider registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  // Product pipeline; stage 0 loads at accept, later stages shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_STAGES; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= pipe0_d;
      for (int i = 1; i < MUL_STAGES; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit (WIDTH=32, MUL_STAGES=2).
// Hand-computed expectations checked with immediate assertions.
module tb_hilo_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  int n;

  hilo_muldiv_unit #(.WIDTH(32), .MUL_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [2:0] o, input logic [31:0] x,
                    input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
    op    = 3'd0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    a     = '0;
    b     = '0;
    flush = 1'b0;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(div_by_zero), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    tick();

    // MULT -3 * 5
    go(3'd1, 32'hFFFF_FFFD, 32'd5);
    chk("mult_busy1", 64'(busy), 64'd1);
    chk("mult_hilo_mid", {hi, lo}, 64'd0);
    tick();
    chk("mult_busy2", 64'(busy), 64'd1);
    chk("mult_done_early", 64'(done), 64'd0);
    tick();
    chk("mult_busy_end", 64'(busy), 64'd0);
    chk("mult_done", 64'(done), 64'd1);
    chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    tick();
    chk("mult_done_pulse", 64'(done), 64'd0);

    // MULTU, then MULT accepted in its done cycle
    go(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    tick();
    chk("multu_done", 64'(done), 64'd1);
    chk("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    go(3'd1, 32'h0001_0000, 32'h0001_0000);
    chk("b2b_busy", 64'(busy), 64'd1);
    tick();
    tick();
    chk("b2b_done", 64'(done), 64'd1);
    chk("b2b_hilo", {hi, lo}, 64'h0000_0001_0000_0000);

    // DIVU 100/7
    go(3'd4, 32'd100, 32'd7);
    wait_idle(n);
    chk("divu_busy_cycles", 64'(n), 64'd32);
    chk("divu_done", 64'(done), 64'd1);
    chk("divu_dz", 64'(div_by_zero), 64'd0);
    chk("divu_hilo", {hi, lo}, {32'd2, 32'd14});
    tick();

    // DIV -7/2
    go(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div_neg_done", 64'(done), 64'd1);
    chk("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    tick();

    // DIV MIN / -1
    go(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("div_min_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
    tick();

    // MTHI / MTLO preload then divide by zero
    go(3'd5, 32'h11, 32'd0);
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_done", 64'(done), 64'd1);
    chk("mthi_hilo", {hi, lo}, 64'h0000_0011_8000_0000);
    go(3'd6, 32'h22, 32'd0);
    chk("mtlo_hilo", {hi, lo}, 64'h0000_0011_0000_0022);
    tick();
    go(3'd3, 32'd55, 32'd0);
    chk("dz_busy", 64'(busy), 64'd0);
    chk("dz_done", 64'(done), 64'd1);
    chk("dz_flag", 64'(div_by_zero), 64'd1);
    chk("dz_hilo", {hi, lo}, 64'h0000_0011_0000_0022);
    tick();
    chk("dz_pulse", 64'(div_by_zero), 64'd0);

    // Flush mid-divide
    go(3'd3, 32'd1000, 32'd3);
    repeat (9) tick();
    chk("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_no_done", 64'(done), 64'd0);
    end
    chk("flush_hilo", {hi, lo}, 64'h0000_0011_0000_0022);

    // Start pulsed mid-op is ignored
    go(3'd3, 32'd1000, 32'd3);
    repeat (5) tick();
    go(3'd4, 32'd5, 32'd1);
    wait_idle(n);
    chk("ign_busy_cycles", 64'(n + 6), 64'd32);
    chk("ign_done", 64'(done), 64'd1);
    chk("ign_hilo", {hi, lo}, {32'd1, 32'd333});
    tick();

    // Start with flush in IDLE, and NONE/reserved ops
    flush = 1'b1;
    go(3'd5, 32'h99, 32'd0);
    flush = 1'b0;
    chk("idle_flush_done", 64'(done), 64'd0);
    chk("idle_flush_hilo", {hi, lo}, {32'd1, 32'd333});
    go(3'd0, 32'h77, 32'd1);
    chk("none_done", 64'(done | busy), 64'd0);
    go(3'd7, 32'h77, 32'd1);
    chk("rsvd_done", 64'(done | busy), 64'd0);
    chk("rsvd_hilo", {hi, lo}, {32'd1, 32'd333});

    // Asynchronous reset mid-divide
    go(3'd3, 32'd1000, 32'd7);
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_hilo", {hi, lo}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_idle", 64'(busy | done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
